// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding and
// address-width helper.
package inst_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LAT  = 2'd1,
    RESPOND   = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  localparam int DEFAULT_DEPTH = 256;

  function automatic int addr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch handshake between the datapath (master) and the instruction memory (slave).
interface inst_mem_responder_if #(
  parameter int WORD_SIZE = 16
);
  logic                 readM;
  logic [WORD_SIZE-1:0] address;
  logic                 inputReady;
  logic                 addr_err;

  modport master (output readM, output address, input inputReady, input addr_err);
  modport slave  (input readM, input address, output inputReady, output addr_err);
endinterface

// File: rtl/inst_mem_responder_store.sv
// Instruction store: one write port, one registered read port; a read and a
// write to the same index on one edge return the old word.
module inst_store #(
  parameter int  WORD_SIZE = 16,
  parameter int  DEPTH     = 256,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Both updates are non-blocking, so the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory slave: accepts a fetch, waits LATENCY cycles, then drives
// the fetched word with inputReady for READY_CYCLES cycles.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int  WORD_SIZE    = 16,
  parameter int  DEPTH        = DEFAULT_DEPTH,
  parameter int  LATENCY      = 2,
  parameter int  READY_CYCLES = 1,
  localparam int ADDR_BITS    = addr_bits(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  inst_mem_responder_if.slave  fetch,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] num_fetch
);

  localparam logic [15:0] LAT_LAST = 16'(LATENCY - 1);
  localparam logic [15:0] RSP_LAST = 16'(READY_CYCLES - 1);

  state_t               state;
  state_t               next_state;
  logic [15:0]          lat_cnt;
  logic [15:0]          lat_nxt;
  logic [15:0]          rsp_cnt;
  logic [15:0]          rsp_nxt;
  logic [WORD_SIZE-1:0] addr_q;
  logic                 ready_q;
  logic                 err_q;
  logic                 capture;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 fetch_done;
  logic [WORD_SIZE-1:0] rdata;

  inst_store #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en & reset_n),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  // Next-state, counter and store-read control.
  always_comb begin
    next_state = state;
    lat_nxt    = lat_cnt;
    rsp_nxt    = rsp_cnt;
    capture    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = addr_q[ADDR_BITS-1:0];
    fetch_done = 1'b0;
    case (state)
      IDLE: begin
        if (fetch.readM) begin
          capture = 1'b1;
          lat_nxt = 16'd0;
          rsp_nxt = 16'd0;
          // Zero latency reads straight from the live address in the accept cycle.
          if (LATENCY == 0) begin
            rd_en      = 1'b1;
            rd_addr    = fetch.address[ADDR_BITS-1:0];
            next_state = RESPOND;
          end else begin
            next_state = WAIT_LAT;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_LAT: begin
        lat_nxt = lat_cnt + 16'd1;
        if (lat_cnt == LAT_LAST) begin
          rd_en      = 1'b1;
          next_state = RESPOND;
        end else begin
          next_state = WAIT_LAT;
        end
      end
      RESPOND: begin
        if (rsp_cnt == RSP_LAST) begin
          fetch_done = 1'b1;
          next_state = WAIT_DROP;
        end else begin
          rsp_nxt    = rsp_cnt + 16'd1;
          next_state = RESPOND;
        end
      end
      WAIT_DROP: begin
        if (!fetch.readM) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_DROP;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and output registers; the strobe follows RESPOND by one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_cnt   <= 16'd0;
      rsp_cnt   <= 16'd0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      num_fetch <= '0;
    end else begin
      state   <= next_state;
      lat_cnt <= lat_nxt;
      rsp_cnt <= rsp_nxt;
      if (capture) begin
        addr_q <= fetch.address;
      end
      ready_q <= (state == RESPOND);
      err_q   <= (state == RESPOND) & (|addr_q[WORD_SIZE-1:ADDR_BITS]);
      if (fetch_done) begin
        num_fetch <= num_fetch + WORD_SIZE'(1);
      end
    end
  end

  assign fetch.inputReady = ready_q;
  assign fetch.addr_err   = err_q;
  assign data             = ready_q ? rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: two builds (LATENCY=2/READY=1 and
// LATENCY=0/READY=3) checked against a scoreboard of expected fetch words.
module tb_inst_mem_responder;

  localparam int LAT_A = 2;
  localparam int RC_A  = 1;
  localparam int LAT_B = 0;
  localparam int RC_B  = 3;
  localparam logic [15:0] RELEASED = 16'hFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  inst_mem_responder_if #(.WORD_SIZE(16)) ia ();
  inst_mem_responder_if #(.WORD_SIZE(16)) ib ();

  tri1 [15:0] data_a;
  tri1 [15:0] data_b;

  logic        load_en_a, load_en_b;
  logic [7:0]  load_addr_a, load_addr_b;
  logic [15:0] load_data_a, load_data_b;
  logic [15:0] num_fetch_a, num_fetch_b;

  inst_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(LAT_A), .READY_CYCLES(RC_A)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch     (ia),
    .data      (data_a),
    .load_en   (load_en_a),
    .load_addr (load_addr_a),
    .load_data (load_data_a),
    .num_fetch (num_fetch_a)
  );

  inst_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(LAT_B), .READY_CYCLES(RC_B)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch     (ib),
    .data      (data_b),
    .load_en   (load_en_b),
    .load_addr (load_addr_b),
    .load_data (load_data_b),
    .num_fetch (num_fetch_b)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          nf_a        = 0;
  int          nf_b        = 0;
  logic [15:0] model_a [256];
  logic [15:0] model_b [256];
  logic [15:0] exp_q [$];
  logic        exp_err_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit sel, input logic r, input logic [15:0] a);
    if (sel) begin
      ib.readM = r; ib.address = a;
    end else begin
      ia.readM = r; ia.address = a;
    end
  endtask

  task automatic set_load(input bit sel, input logic en, input int idx, input logic [15:0] val);
    if (sel) begin
      load_en_b = en; load_addr_b = 8'(idx); load_data_b = val;
      if (en) model_b[idx] = val;
    end else begin
      load_en_a = en; load_addr_a = 8'(idx); load_data_a = val;
      if (en) model_a[idx] = val;
    end
  endtask

  function automatic logic [15:0] obs_data(input bit sel);
    return sel ? data_b : data_a;
  endfunction

  function automatic logic obs_rdy(input bit sel);
    return sel ? ib.inputReady : ia.inputReady;
  endfunction

  function automatic logic obs_err(input bit sel);
    return sel ? ib.addr_err : ia.addr_err;
  endfunction

  // One fetch: push expectation, accept, then walk a bounded window of cycles.
  task automatic fetch(input bit sel, input logic [15:0] addr, input bit hold,
                       input int wr_k, input logic [15:0] wr_val, input string tag);
    int          lat = sel ? LAT_B : LAT_A;
    int          rc  = sel ? RC_B : RC_A;
    int          idx = int'(addr[7:0]);
    logic [15:0] ed  = 16'h0000;
    logic        ee  = 1'b0;
    exp_q.push_back(sel ? model_b[idx] : model_a[idx]);
    exp_err_q.push_back(addr > 16'h00FF);
    set_req(sel, 1'b1, addr);
    tick();
    set_req(sel, hold, addr ^ 16'h0002);
    for (int k = 1; k <= lat + rc + 1; k++) begin
      if (k == wr_k) set_load(sel, 1'b1, idx, wr_val);
      tick();
      if (k == wr_k) set_load(sel, 1'b0, 0, 16'h0000);
      if (k == lat + 1) begin
        ed = exp_q.pop_front();
        ee = exp_err_q.pop_front();
      end
      if (k >= lat + 1 && k <= lat + rc) begin
        check({tag, "_ready"}, {15'd0, obs_rdy(sel)}, 16'd1);
        check({tag, "_data"}, obs_data(sel), ed);
        check({tag, "_err"}, {15'd0, obs_err(sel)}, {15'd0, ee});
      end else begin
        check({tag, "_idle_ready"}, {15'd0, obs_rdy(sel)}, 16'd0);
        check({tag, "_idle_data"}, obs_data(sel), RELEASED);
        check({tag, "_idle_err"}, {15'd0, obs_err(sel)}, 16'd0);
      end
    end
    if (sel) nf_b++; else nf_a++;
    check({tag, "_num_fetch"}, sel ? num_fetch_b : num_fetch_a, 16'(sel ? nf_b : nf_a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    set_req(1'b0, 1'b0, 16'h0000);
    set_req(1'b1, 1'b0, 16'h0000);
    set_load(1'b0, 1'b0, 0, 16'h0000);
    set_load(1'b1, 1'b0, 0, 16'h0000);
    for (int i = 0; i < 256; i++) begin
      model_a[i] = 16'h0000;
      model_b[i] = 16'h0000;
    end

    // Load the store while reset is held; loads are honoured during reset.
    for (int i = 0; i < 4; i++) begin
      logic [15:0] w;
      case (i)
        0: w = 16'h4000;
        1: w = 16'h6001;
        2: w = 16'hF01C;
        default: w = 16'h9005;
      endcase
      set_load(1'b0, 1'b1, i, w);
      set_load(1'b1, 1'b1, i, w);
      tick();
    end
    set_load(1'b0, 1'b0, 0, 16'h0000);
    set_load(1'b1, 1'b0, 0, 16'h0000);
    tick();
    check("rst_ready_a", {15'd0, ia.inputReady}, 16'd0);
    check("rst_err_a", {15'd0, ia.addr_err}, 16'd0);
    check("rst_data_a", data_a, RELEASED);
    check("rst_num_a", num_fetch_a, 16'd0);
    check("rst_ready_b", {15'd0, ib.inputReady}, 16'd0);
    check("rst_data_b", data_b, RELEASED);
    check("rst_num_b", num_fetch_b, 16'd0);
    reset_n = 1'b1;
    tick();

    // readM held through the response and one cycle beyond: single response.
    fetch(1'b0, 16'h0000, 1'b1, 0, 16'h0000, "a_addr0_hold");
    tick();
    check("hold_no_refetch", {15'd0, ia.inputReady}, 16'd0);
    set_req(1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    check("hold_drop_ready", {15'd0, ia.inputReady}, 16'd0);
    check("hold_num_fetch", num_fetch_a, 16'd1);

    fetch(1'b0, 16'h0001, 1'b0, 0, 16'h0000, "a_addr1");

    // Zero latency, three ready cycles.
    fetch(1'b1, 16'h0002, 1'b0, 0, 16'h0000, "b_addr2");

    // Out-of-range address wraps and flags addr_err.
    fetch(1'b0, 16'h0103, 1'b0, 0, 16'h0000, "a_addr103");

    // Load on the capture edge returns the old word; refetch sees the new one.
    fetch(1'b0, 16'h0001, 1'b0, LAT_A, 16'hABCD, "a_rbw_old");
    fetch(1'b0, 16'h0001, 1'b0, 0, 16'h0000, "a_rbw_new");
    check("rbw_model", model_a[1], 16'hABCD);

    // Reset during WAIT_LAT discards the fetch.
    set_req(1'b0, 1'b1, 16'h0000);
    tick();
    set_req(1'b0, 1'b0, 16'h0000);
    reset_n = 1'b0;
    tick();
    nf_a = 0;
    nf_b = 0;
    check("midrst_ready", {15'd0, ia.inputReady}, 16'd0);
    check("midrst_data", data_a, RELEASED);
    check("midrst_num_a", num_fetch_a, 16'd0);
    check("midrst_num_b", num_fetch_b, 16'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("postrst_ready", {15'd0, ia.inputReady}, 16'd0);
      check("postrst_data", data_a, RELEASED);
    end
    fetch(1'b0, 16'h0000, 1'b0, 0, 16'h0000, "a_after_rst");
    fetch(1'b1, 16'h0003, 1'b0, 0, 16'h0000, "b_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory slave directly upstream of the single-cycle datapath.
- Services the datapath's fetch handshake: readM level request plus 16-bit address in; instruction word on shared data bus plus inputReady pulse out.
- Holds a DEPTH-word instruction store, loaded through a side port by the bench/loader.
- Response latency is programmable.

Parameters:
- WORD_SIZE, 16, data/address width
- DEPTH, 256, instruction words stored; power of two
- LATENCY, 2, clk cycles from request accept to inputReady assertion; 0 allowed
- READY_CYCLES, 1, cycles inputReady and data stay asserted/driven per response; >=1

Ports:
- clk  input  1  clock, all state updates on posedge
- reset_n  input  1  synchronous active-low reset, sampled on posedge clk
- readM  input  1  fetch request level from datapath
- address  input  WORD_SIZE  fetch address (word index)
- data  inout  WORD_SIZE  driven with fetched word during response, else high-Z
- inputReady  output  1  response strobe to datapath
- load_en  input  1  write enable for store
- load_addr  input  log2(DEPTH)  store write index
- load_data  input  WORD_SIZE  store write data
- addr_err  output  1  high alongside inputReady when address >= DEPTH
- num_fetch  output  WORD_SIZE  count of completed responses

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE; inputReady=0; data=Z; addr_err=0; num_fetch=0; latency counter=0.
  - Store contents are NOT cleared; load_en is still honoured during reset.
- FSM states: IDLE, WAIT_LAT, RESPOND, WAIT_DROP.
- IDLE:
  - readM=1 at posedge: capture address into addr_q; clear counter.
  - Next state is WAIT_LAT, or RESPOND when LATENCY=0.
- WAIT_LAT:
  - Counter increments each cycle.
  - When counter reaches LATENCY-1: read store at addr_q[log2(DEPTH)-1:0] into rdata_q, then move to RESPOND.
  - With LATENCY=0, the read happens in the IDLE accept cycle.
- RESPOND:
  - inputReady=1; data=rdata_q; addr_err=|addr_q[WORD_SIZE-1:log2(DEPTH)].
  - Held for READY_CYCLES cycles.
  - On the last cycle: num_fetch increments (wraps 16'hFFFF->0); next state WAIT_DROP.
- WAIT_DROP:
  - inputReady=0; data=Z.
  - Stay until readM sampled 0, then IDLE.
  - Prevents a still-high readM from being re-accepted as a new fetch.
- Latency: readM high at edge N -> inputReady high from edge N+LATENCY+1 through N+LATENCY+READY_CYCLES.
- readM drops during WAIT_LAT: response still completes, no abort.
- Address changes after accept: ignored; only addr_q is used.
- Out-of-range address: index wraps modulo DEPTH; addr_err flags the response.
- Load write to the index being fetched:
  - Visible if the write's edge precedes the rdata_q capture edge.
  - In the same cycle as capture, the old value is returned (read-before-write).
- Reset asserted mid-response: next posedge returns to IDLE; inputReady drops; data goes Z immediately after that edge; in-flight fetch is discarded.
- data bus: only this block drives data, and only in RESPOND. It never drives while inputReady=0.

Decomposition:
- Shared package (opcodes include companion):
  - FSM state encoding as localparam constants, 2 bits: IDLE=0, WAIT_LAT=1, RESPOND=2, WAIT_DROP=3.
  - Derived ADDR_BITS = $clog2(DEPTH).
- One natural sub-module: inst_store — synchronous single-write, single-read array (DEPTH x WORD_SIZE) with registered read, read-before-write.
- FSM, counter, tri-state and num_fetch stay in the top.

Test Plan:
- Load store[0..3]=16'h4000,16'h6001,16'hF01C,16'h9005; reset; readM=1 addr=0 with LATENCY=2 -> inputReady high exactly 3 cycles after accept edge for 1 cycle, data=16'h4000, addr_err=0, num_fetch=1.
- readM held high across the whole response, then dropped one cycle later -> exactly one response, num_fetch=1; next readM=1 addr=1 -> data=16'h6001, num_fetch=2.
- Rebuild with LATENCY=0, READY_CYCLES=3; fetch addr=2 -> inputReady high on the edge after accept for 3 consecutive cycles, data=16'hF01C throughout, Z before and after.
- Fetch address 16'h0103 with DEPTH=256 -> data=store[3]=16'h9005, addr_err=1 during inputReady, 0 otherwise.
- load_en writes store[1]=16'hABCD on the capture edge of a fetch to addr=1 -> old 16'h6001 returned; immediate refetch -> 16'hABCD.
- reset_n=0 asserted during WAIT_LAT -> no inputReady, data=Z, num_fetch=0; after release, fetch addr=0 -> 16'h4000 (store retained).
